// File: rtl/piso_bit_serializer_if.sv
// Load handshake and serial output bundle for piso_bit_serializer.
// The source drives the master modport; the serializer uses the slave modport.
interface piso_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             d_out;
    logic             d_out_valid;
    logic             frame_done;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  d_out,
        input  d_out_valid,
        input  frame_done
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output d_out,
        output d_out_valid,
        output frame_done
    );
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: one bit per clk, gapless back-to-back words.
// Optional macro PARITY_EN appends an even-parity bit to every frame.
module piso_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    piso_bit_serializer_if.slave  bus
);

`ifdef PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam int CNT_W = $clog2(LAST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_out_q, d_out_d;
    logic             d_out_valid_q, d_out_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             load_ready_q, load_ready_d;
`ifdef PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             accept;
    logic             last;
    logic             head;

    // Outputs are computed from the next state so they leave the flops directly.
    always_comb begin
        accept  = bus.load_valid && load_ready_q;
        last    = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef PARITY_EN
        parity_d = parity_q;
`endif
        if (accept) begin
            state_d = SHIFT;
            sreg_d  = bus.load_data;
            cnt_d   = '0;
`ifdef PARITY_EN
            parity_d = ^bus.load_data;
`endif
        end else if (state_q == SHIFT) begin
            if (last) begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end else begin
                sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, sreg_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
            end
        end

        head = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
`ifdef PARITY_EN
        if (cnt_d == CNT_W'(WIDTH)) begin
            head = parity_d;
        end
`endif
        d_out_valid_d = (state_d == SHIFT);
        d_out_d       = d_out_valid_d && head;
        frame_done_d  = d_out_valid_d && (cnt_d == LAST_CNT);
        load_ready_d  = !d_out_valid_d || frame_done_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sreg_q        <= '0;
            cnt_q         <= '0;
            d_out_q       <= 1'b0;
            d_out_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            load_ready_q  <= 1'b1;
`ifdef PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            cnt_q         <= cnt_d;
            d_out_q       <= d_out_d;
            d_out_valid_q <= d_out_valid_d;
            frame_done_q  <= frame_done_d;
            load_ready_q  <= load_ready_d;
`ifdef PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign bus.d_out       = d_out_q;
    assign bus.d_out_valid = d_out_valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.load_ready  = load_ready_q;

endmodule
